// File: rtl/cla_sub_seq.sv
// ---------------------------------------------------------------------------
// cla_slice
//   Purpose : SLICE-bit carry-lookahead adder slice. Every carry is formed
//             directly from the generate/propagate terms and the slice
//             carry-in, so no carry ripples through the slice.
//   Ports   : a, b  [SLICE-1:0]  addends
//             cin                slice carry-in
//             sum   [SLICE-1:0]  a + b + cin (low SLICE bits)
//             cout               carry-out of the slice
// ---------------------------------------------------------------------------
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    // prod accumulates the running propagate product from bit i downwards.
    always_comb begin
        logic prod;
        logic term;
        c    = '0;
        prod = 1'b0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            prod = 1'b1;
            term = 1'b0;
            for (int j = i; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & cin);
        end
    end

    assign sum  = p ^ c[SLICE-1:0];
    assign cout = c[SLICE];

endmodule

// ---------------------------------------------------------------------------
// cla_sub_seq
//   Purpose : Sequential WIDTH-bit unsigned subtractor, diff = a - b, done as
//             a + ~b + 1 through one cla_slice, one SLICE-bit slice per cycle,
//             LSB slice first. Valid/ready handshake on both sides.
//   Ports   : clk, rst            clock, synchronous active-high reset
//             in_valid/in_ready   operand handshake (a, b captured on accept)
//             a, b   [WIDTH-1:0]  minuend, subtrahend (unsigned)
//             out_valid/out_ready result handshake
//             diff   [WIDTH-1:0]  (a - b) mod 2^WIDTH
//             borrow              1 iff a < b
//   Timing  : out_valid rises NSL cycles after the accept edge; the block is
//             busy until the output handshake, after which it accepts again
//             on the following cycle.
// ---------------------------------------------------------------------------
module cla_sub_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
            $error("cla_sub_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [NSL-1:0][SLICE-1:0] a_r;
    logic [NSL-1:0][SLICE-1:0] nb_r;     // subtrahend stored already inverted
    logic [NSL-1:0][SLICE-1:0] diff_r;
    logic                      carry;
    logic [IW-1:0]             idx;

    logic [SLICE-1:0]          s_sum;
    logic                      s_cout;

    cla_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_r[idx]),
        .b    (nb_r[idx]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff_r    <= '0;
            borrow    <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            nb_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        nb_r     <= ~b;
                        carry    <= 1'b1;   // the +1 of two's complement
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    diff_r[idx] <= s_sum;
                    carry       <= s_cout;
                    if (idx == LAST) begin
                        // final carry-out of a + ~b + 1 is the "no borrow" flag
                        borrow    <= ~s_cout;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    idx       <= '0;
                end
            endcase
        end
    end

    assign diff = diff_r;

endmodule

// File: tb/tb_cla_sub_seq.sv
module tb_cla_sub_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    typedef struct packed {
        logic       bw;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_cmp = 0;
    int   n_err = 0;

    cla_sub_seq #(.WIDTH(8), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t gold(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] g;
        g = {1'b0, x} - {1'b0, y};
        return {g[8], g[7:0]};
    endfunction

    // Drive one operand pair and let it be accepted on the next edge.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        sb.push_back(gold(x, y));
        chk("busy_in_ready", in_ready, 0);
        chk("early_out_valid", out_valid, 0);
    endtask

    // Wait (bounded) for out_valid, check latency and the scoreboard head.
    task automatic wait_result;
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick;
            lat++;
            chk("calc_in_ready", in_ready, 0);
        end
        chk("latency", lat, 2);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            last_e = sb.pop_front();
            chk("diff", diff, last_e.d);
            chk("borrow", borrow, last_e.bw);
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    task automatic op(input logic [7:0] x, input logic [7:0] y);
        start_op(x, y);
        wait_result();
        handshake();
    endtask

    initial begin
        logic [7:0] pa [5];
        logic [7:0] pb [5];
        int nacc, nres, t_hs;
        logic acc, hs;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick; tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        rst = 1'b0;
        tick;

        // latency, wrap and cross-slice carry
        op(8'd5, 8'd3);
        op(8'd3, 8'd5);
        op(8'h00, 8'h01);
        op(8'h80, 8'h01);
        op(8'hFF, 8'hFF);

        // exhaustive low sweep, then random pairs
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                op(8'(i), 8'(j));
        for (int k = 0; k < 1000; k++)
            op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // backpressure: result held, inputs ignored
        start_op(8'hA5, 8'h3C);
        wait_result();
        for (int k = 0; k < 10; k++) begin
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            in_valid = k[0];
            tick;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, last_e.d);
            chk("bp_borrow", borrow, last_e.bw);
        end
        in_valid = 1'b0;
        handshake();
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("bp_no_extra", out_valid, 0);
        end

        // reset one cycle after accept aborts the operation
        start_op(8'hF0, 8'h0F);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sb.delete();
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("abort_no_out", out_valid, 0);
        end
        op(8'd9, 8'd9);

        // back-to-back with in_valid and out_ready held high
        pa = '{8'h10, 8'h00, 8'hFF, 8'h42, 8'h01};
        pb = '{8'h01, 8'h01, 8'hFF, 8'h43, 8'h80};
        a = pa[0]; b = pb[0];
        in_valid = 1'b1; out_ready = 1'b1;
        nacc = 0; nres = 0; t_hs = -10;
        for (int t = 0; t < 100 && nres < 5; t++) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("b2b_sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("b2b_diff", diff, e.d);
                    chk("b2b_borrow", borrow, e.bw);
                end
                nres++;
                t_hs = t;
            end
            if (acc) begin
                if (nacc > 0) chk("b2b_spacing", t, t_hs + 1);
                sb.push_back(gold(a, b));
                nacc++;
            end
            tick;
            if (acc) begin
                if (nacc < 5) begin
                    a = pa[nacc];
                    b = pb[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", nres, 5);
        out_ready = 1'b0;
        tick;
        chk("b2b_idle", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
